// File: rtl/baud_frac_gen.sv
// Fractional baud-rate generator: acquisition ticks with a first-order fractional period,
// plus bit-boundary and mid-bit pulses derived from a programmable oversampling count.
module baud_frac_gen #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned FRAC_W   = 8,
    parameter int unsigned OVS_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                BaudEn_i,
    input  logic [PERIOD_W-1:0] AcqPeriod_i,
    input  logic [FRAC_W-1:0]   AcqFrac_i,
    input  logic [OVS_W-1:0]    OvsRate_i,
    input  logic                Resync_i,
    output logic                AcqSig_o,
    output logic                BaudSig_o,
    output logic                MidSig_o
);

    // One extra bit so the counter can reach P_s + ext when P_s is at its maximum.
    logic [PERIOD_W:0]   cntQ, cntD;
    logic                extQ, extD;
    logic [FRAC_W-1:0]   accQ, accD;
    logic [OVS_W-1:0]    ovsQ, ovsD;
    logic [PERIOD_W-1:0] periodQ, periodD;
    logic [FRAC_W-1:0]   fracQ, fracD;
    logic [OVS_W-1:0]    ovsRateQ, ovsRateD;
    logic                acqQ, acqD, baudQ, baudD, midQ, midD;

    logic [PERIOD_W:0]   periodEff;
    logic [FRAC_W:0]     accSum;
    logic [OVS_W-1:0]    nEff;
    logic                tick, bitEnd, midPt;

    always_comb begin
        periodEff = {1'b0, periodQ} + {{PERIOD_W{1'b0}}, extQ};
        tick      = (cntQ == periodEff);
        accSum    = {1'b0, accQ} + {1'b0, fracQ};
        nEff      = (ovsRateQ < OVS_W'(2)) ? OVS_W'(2) : ovsRateQ;
        bitEnd    = (ovsQ == nEff - OVS_W'(1));
        midPt     = (ovsQ == (nEff >> 1) - OVS_W'(1));
    end

    always_comb begin
        cntD     = cntQ;
        extD     = extQ;
        accD     = accQ;
        ovsD     = ovsQ;
        periodD  = periodQ;
        fracD    = fracQ;
        ovsRateD = ovsRateQ;
        acqD     = 1'b0;
        baudD    = 1'b0;
        midD     = 1'b0;
        if (!BaudEn_i || Resync_i) begin
            // Disable and resync both restart bit timing from scratch with fresh config.
            cntD     = '0;
            extD     = 1'b0;
            accD     = '0;
            ovsD     = '0;
            periodD  = AcqPeriod_i;
            fracD    = AcqFrac_i;
            ovsRateD = OvsRate_i;
        end else if (tick) begin
            cntD = '0;
            accD = accSum[FRAC_W-1:0];
            extD = accSum[FRAC_W];
            acqD = 1'b1;
            midD = midPt;
            if (bitEnd) begin
                ovsD     = '0;
                baudD    = 1'b1;
                // Config only changes at a bit boundary so a bit is never stretched mid-way.
                periodD  = AcqPeriod_i;
                fracD    = AcqFrac_i;
                ovsRateD = OvsRate_i;
            end else begin
                ovsD = ovsQ + OVS_W'(1);
            end
        end else begin
            cntD = cntQ + (PERIOD_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntQ     <= '0;
            extQ     <= 1'b0;
            accQ     <= '0;
            ovsQ     <= '0;
            periodQ  <= '0;
            fracQ    <= '0;
            ovsRateQ <= '0;
            acqQ     <= 1'b0;
            baudQ    <= 1'b0;
            midQ     <= 1'b0;
        end else begin
            cntQ     <= cntD;
            extQ     <= extD;
            accQ     <= accD;
            ovsQ     <= ovsD;
            periodQ  <= periodD;
            fracQ    <= fracD;
            ovsRateQ <= ovsRateD;
            acqQ     <= acqD;
            baudQ    <= baudD;
            midQ     <= midD;
        end
    end

    assign AcqSig_o  = acqQ;
    assign BaudSig_o = baudQ;
    assign MidSig_o  = midQ;

endmodule

// File: doc/baud_frac_gen.md
# baud_frac_gen

Parametrised fractional baud-rate generator for the UART core. It produces the per-bit timing that both the TX shifter and the RX sampler consume. The acquisition tick period is set as an integer clock count plus a fractional term in a first-order accumulator, so the average period is exact to 1/2^FRAC_W clock. The acquisition-to-bit oversampling ratio is programmable. Outputs are an acquisition tick, a bit-boundary pulse and a mid-bit sample pulse. An RX-driven resync input realigns bit phase to a start edge.

## Interface
- PERIOD_W, 16, width of integer acquisition period field
- FRAC_W, 8, width of fractional accumulator and fraction field
- OVS_W, 5, width of oversampling-ratio field
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset; released synchronously to clk
- BaudEn_i  in  1  generator enable; low holds all state cleared
- AcqPeriod_i  in  PERIOD_W  integer acquisition period minus one (P)
- AcqFrac_i  in  FRAC_W  fractional clocks added per acquisition tick (F)
- OvsRate_i  in  OVS_W  acquisition ticks per bit (N); values 0 and 1 are treated as 2
- Resync_i  in  1  single-cycle request to restart bit timing
- AcqSig_o  out  1  acquisition tick, one clk wide
- BaudSig_o  out  1  bit-boundary pulse, one clk wide, coincident with the last AcqSig_o of a bit
- MidSig_o  out  1  mid-bit pulse, one clk wide, coincident with acquisition tick N>>1 of a bit

## Operation
- State: period counter cnt (PERIOD_W), extend flag ext, accumulator acc (FRAC_W), tick counter ovs (OVS_W), and shadow registers P_s, F_s, N_s.
- Shadow load:
  - Shadows load from the inputs on every edge while BaudEn_i is low, on Resync_i, and on every edge where BaudSig_o is asserted next.
  - Config changes mid-bit take effect at the next bit boundary only.
- Effective period: P_eff = P_s + ext, computed at PERIOD_W+1 bits so there is no wrap when P_s is at its maximum.
- Each enabled edge:
  - If cnt == P_eff: cnt <= 0 and a tick occurs. Otherwise cnt <= cnt+1.
- On a tick:
  - {carry, acc} <= acc + F_s, and ext <= carry.
  - If ovs == N_s-1: ovs <= 0 and this is a bit boundary. Otherwise ovs <= ovs+1.
- Outputs are registered and asserted the cycle after the deciding edge:
  - AcqSig_o = tick.
  - BaudSig_o = tick AND bit boundary.
  - MidSig_o = tick AND ovs == (N_s>>1)-1.
- Average tick period is P+1+F/2^FRAC_W clocks. The average bit period is N times that.
- Resync_i:
  - Has priority over the tick.
  - Clears cnt, ext, acc and ovs, and reloads the shadows.
  - Forces all outputs to 0 on the following cycle.
  - The next bit's timing starts from the edge after Resync_i.
- BaudEn_i low:
  - Synchronously clears cnt, ext, acc and ovs.
  - All outputs are 0 from the next cycle.
  - No partial pulse is emitted.
- P_s = 0 with ext = 0 gives a tick on every cycle. This is legal.

## Timing
- Reset values: AcqSig_o, BaudSig_o, MidSig_o, cnt, ext, acc and ovs are all 0. Shadows are 0, and N_s = 0 behaves as 2.
- Edge 1 is the first edge with BaudEn_i high. The first AcqSig_o is high in the cycle after edge P+1.
- Tick-to-tick spacing is P+1 clocks, or P+2 when ext is set.
- Latency from a deciding edge to its output is one cycle. BaudSig_o and MidSig_o are never asserted without AcqSig_o.
- With N = 2, MidSig_o coincides with the first tick and BaudSig_o with the second.
- For odd N, mid falls at tick floor(N/2).
- Resync_i and BaudEn_i low in the same cycle: disable wins. The shadows still load.

## Test plan
- P=3, F=0, N=4, enable held high. Required: AcqSig_o every 4 clocks, the first after edge 4; MidSig_o on tick 2 (clock 8); BaudSig_o on tick 4 (clock 16), repeating every 16.
- P=3, F=128, FRAC_W=8, N=8. Required: tick spacings 4,4,5,4,5,…; 8 bits total exactly 8·8·4.5 = 288 clocks after the first boundary; no drift over 1000 bits.
- P=0, F=0, N=2. Required: AcqSig_o high every cycle, with MidSig_o and BaudSig_o alternating every cycle.
- Change P from 3 to 7 at tick 2 of a bit with N=4. Required: the remaining ticks of that bit stay 4 clocks apart; the ticks after the BaudSig_o are 8 clocks apart.
- Resync_i pulse at cnt=2, ovs=3, N=8. Required: outputs 0 on the next cycle; the next AcqSig_o arrives P+1 clocks after the edge following Resync_i; MidSig_o on the 4th tick after resync.
- Drop BaudEn_i mid-bit, then assert rst low mid-bit in a second run. Required: all outputs 0 by the next cycle (disable) or immediately (reset), and timing restarts from edge 1 on re-enable.
